// File: rtl/mem_responder_pkg.sv
// Shared request-type and FSM-state encodings for the memory responder.
package MacroDef;

  typedef enum logic [2:0] {
    TYPE_BYTE = 3'b000,
    TYPE_HALF = 3'b001,
    TYPE_WORD = 3'b010,
    TYPE_LINE = 3'b100
  } req_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder.sv
// Cache-side memory responder: serves single-word and line reads/writes
// against an external synchronous RAM with 1-cycle read latency.
module mem_responder
  import MacroDef::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned RAM_AW     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    ram_en,
  output logic [3:0]              ram_we,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned CW = OW + 1;

  state_e                  state, state_nx;
  logic [CW-1:0]           cnt, beats;
  logic [RAM_AW-1:0]       base;
  logic [3:0]              wmask;
  logic [32*LINE_WORDS-1:0] wbuf;
  logic                    rv_q, rl_q;
  logic                    rd_acc, wr_acc, issue_rd, issue_wr, last_issue;
  logic                    unused_addr_bits;

  function automatic logic [RAM_AW-1:0] line_base(input logic [RAM_AW-1:0] w,
                                                  input logic line);
    line_base = w;
    if (line) line_base[OW-1:0] = '0;
  endfunction

  always_comb begin
    unused_addr_bits = ^{rd_addr[31:RAM_AW+2], rd_addr[1:0],
                         wr_addr[31:RAM_AW+2], wr_addr[1:0]};
  end

  // Write wins a same-cycle tie so a victim writeback lands before its refill.
  always_comb begin
    wr_acc     = (state == IDLE) && wr_req;
    rd_acc     = (state == IDLE) && rd_req && !wr_req;
    issue_rd   = (state == RD_BURST) && (cnt < beats);
    issue_wr   = (state == WR_BURST);
    last_issue = (cnt == beats - CW'(1));
    state_nx   = state;
    unique case (state)
      IDLE: begin
        if (wr_acc)      state_nx = WR_BURST;
        else if (rd_acc) state_nx = RD_BURST;
      end
      RD_BURST: if (rl_q) state_nx = IDLE;
      WR_BURST: if (last_issue) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_rdy    = !rst && (state == IDLE) && !wr_req;
    wr_rdy    = !rst && (state == IDLE);
    ret_valid = !rst && rv_q;
    ret_last  = !rst && rl_q;
    ret_data  = ret_valid ? ram_rdata : '0;
    ram_en    = !rst && (issue_rd || issue_wr);
    ram_we    = (!rst && issue_wr) ? wmask : '0;
    ram_addr  = ram_en ? base + RAM_AW'(cnt) : '0;
    ram_wdata = (!rst && issue_wr) ? wbuf[32*cnt[OW-1:0] +: 32] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      beats <= '0;
      base  <= '0;
      wmask <= '0;
      wbuf  <= '0;
      rv_q  <= 1'b0;
      rl_q  <= 1'b0;
    end else begin
      state <= state_nx;
      rv_q  <= issue_rd;
      rl_q  <= issue_rd && last_issue;
      if (wr_acc) begin
        cnt   <= '0;
        beats <= (wr_type == TYPE_LINE) ? CW'(LINE_WORDS) : CW'(1);
        base  <= line_base(wr_addr[RAM_AW+1:2], wr_type == TYPE_LINE);
        wmask <= (wr_type == TYPE_LINE) ? 4'hF : wr_wstrb;
        wbuf  <= wr_data;
      end else if (rd_acc) begin
        cnt   <= '0;
        beats <= (rd_type == TYPE_LINE) ? CW'(LINE_WORDS) : CW'(1);
        base  <= line_base(rd_addr[RAM_AW+1:2], rd_type == TYPE_LINE);
      end else if (issue_rd || issue_wr) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed literal scenarios followed by
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned NSLOT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_req, wr_req;
  logic [2:0]       rd_type, wr_type;
  logic [31:0]      rd_addr, wr_addr;
  logic [3:0]       wr_wstrb;
  logic [32*LW-1:0] wr_data;
  logic             rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [31:0]      ret_data;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  mem_responder #(.LINE_WORDS(LW), .RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // External RAM: read-first, byte-enabled, 1-cycle read latency.
  logic [31:0] ram [1 << AW];
  logic [31:0] rdq;
  always @(posedge clk) begin
    if (ram_en) begin
      rdq = ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      ram_rdata <= rdq;
    end
  end

  always @(posedge clk) cyc++;

  // Transaction-level model: per-cycle expectation slots filled at accept time.
  logic [31:0] shadow [1 << AW];
  logic        exp_en [NSLOT];
  logic [3:0]  exp_we [NSLOT];
  logic [31:0] exp_addr [NSLOT];
  logic [31:0] exp_wd [NSLOT];
  logic        exp_rv [NSLOT];
  logic        exp_rl [NSLOT];
  logic [31:0] exp_rd [NSLOT];
  int unsigned free_at = 0;

  initial begin
    for (int i = 0; i < NSLOT; i++) begin
      exp_en[i] = 0; exp_we[i] = 0; exp_addr[i] = 0; exp_wd[i] = 0;
      exp_rv[i] = 0; exp_rl[i] = 0; exp_rd[i] = 0;
    end
  end

  always @(negedge clk) begin
    int unsigned s, n, sl, a, bw;
    logic idle, line;
    s = cyc % NSLOT;
    if (rst) begin
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_wr_rdy", wr_rdy, 0);
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_ret_last", ret_last, 0);
      chk("rst_ret_data", ret_data, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      for (int i = 0; i < NSLOT; i++) begin
        exp_en[i] = 0; exp_we[i] = 0; exp_rv[i] = 0; exp_rl[i] = 0;
      end
      free_at = cyc + 1;
    end else begin
      idle = (cyc >= free_at);
      chk("wr_rdy", wr_rdy, idle);
      chk("rd_rdy", rd_rdy, idle && !wr_req);
      chk("ret_valid", ret_valid, exp_rv[s]);
      chk("ret_last", ret_last, exp_rl[s]);
      if (exp_rv[s]) chk("ret_data", ret_data, exp_rd[s]);
      chk("ram_en", ram_en, exp_en[s]);
      chk("ram_we", ram_we, exp_en[s] ? exp_we[s] : 4'h0);
      if (exp_en[s]) chk("ram_addr", 32'(ram_addr), exp_addr[s]);
      if (exp_en[s] && exp_we[s] != 0) begin
        chk("ram_wdata", ram_wdata, exp_wd[s]);
        for (int b = 0; b < 4; b++)
          if (exp_we[s][b]) shadow[exp_addr[s]][8*b +: 8] = exp_wd[s][8*b +: 8];
      end
      exp_en[s] = 0; exp_we[s] = 0; exp_rv[s] = 0; exp_rl[s] = 0;
      if (idle && wr_req) begin
        line = (wr_type == 3'b100);
        n  = line ? LW : 1;
        bw = (wr_addr >> 2) % (1 << AW);
        if (line) bw = bw - (bw % LW);
        for (int i = 0; i < int'(n); i++) begin
          sl = (cyc + 1 + i) % NSLOT;
          exp_en[sl]   = 1;
          exp_we[sl]   = line ? 4'hF : wr_wstrb;
          exp_addr[sl] = (bw + i) % (1 << AW);
          exp_wd[sl]   = line ? wr_data[32*i +: 32] : wr_data[31:0];
        end
        free_at = cyc + 1 + n;
      end else if (idle && rd_req) begin
        line = (rd_type == 3'b100);
        n  = line ? LW : 1;
        bw = (rd_addr >> 2) % (1 << AW);
        if (line) bw = bw - (bw % LW);
        for (int i = 0; i < int'(n); i++) begin
          a  = (bw + i) % (1 << AW);
          sl = (cyc + 1 + i) % NSLOT;
          exp_en[sl] = 1; exp_we[sl] = 0; exp_addr[sl] = a;
          sl = (cyc + 2 + i) % NSLOT;
          exp_rv[sl] = 1; exp_rd[sl] = shadow[a]; exp_rl[sl] = (i == int'(n) - 1);
        end
        free_at = cyc + 2 + n;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rand_type();
    logic [2:0] t;
    t = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) t = 3'b100;
    return t;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] region;
    region = ($urandom_range(0, 1) == 1) ? 32'h0003_FE00 : 32'h0;
    return ($urandom & 32'hFFFC_0000) | region | 32'($urandom_range(0, 511));
  endfunction

  initial begin
    rst = 1; rd_req = 0; wr_req = 0; rd_type = 0; wr_type = 0;
    rd_addr = 0; wr_addr = 0; wr_wstrb = 0; wr_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    end
    for (int i = 0; i < 4; i++) ram[4 + i] = 32'hA0A0_0000 + 32'(i);
    ram[32'h40] = 32'h1234_5678;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = ram[i];

    repeat (3) step;
    @(negedge clk);
    chk("lit_rst_rd_rdy", rd_rdy, 0);
    chk("lit_rst_wr_rdy", wr_rdy, 0);
    step; rst = 0;
    @(negedge clk);
    chk("lit_post_rst_rd_rdy", rd_rdy, 1);
    chk("lit_post_rst_wr_rdy", wr_rdy, 1);

    // Line read at 0x14 returns words 4..7.
    step; rd_req = 1; rd_type = 3'b100; rd_addr = 32'h14;
    @(negedge clk); chk("lit_line_acc", rd_rdy, 1);
    step; rd_req = 0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("lit_line_valid", ret_valid, j >= 2);
      chk("lit_line_last", ret_last, j == 5);
      if (j >= 2) chk("lit_line_data", ret_data, 32'hA0A0_0000 + 32'(j - 2));
      step;
    end
    @(negedge clk); chk("lit_line_rdy_after", rd_rdy, 1);

    // Byte read at 0x103 returns the whole word 0x40.
    step; rd_req = 1; rd_type = 3'b000; rd_addr = 32'h103;
    @(negedge clk); chk("lit_byte_acc", rd_rdy, 1);
    step; rd_req = 0;
    @(negedge clk); chk("lit_byte_early", ret_valid, 0);
    step;
    @(negedge clk);
    chk("lit_byte_valid", ret_valid, 1);
    chk("lit_byte_data", ret_data, 32'h1234_5678);
    chk("lit_byte_last", ret_last, 1);
    step;
    @(negedge clk); chk("lit_byte_rdy", rd_rdy, 1);

    // Same-cycle write and read to line 0x20: write first.
    step;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h20;
    wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h20;
    @(negedge clk);
    chk("lit_sim_wr_rdy", wr_rdy, 1);
    chk("lit_sim_rd_rdy", rd_rdy, 0);
    step; wr_req = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("lit_sim_en", ram_en, 1);
      chk("lit_sim_we", ram_we, 4'hF);
      chk("lit_sim_addr", 32'(ram_addr), 32'(8 + j));
      chk("lit_sim_wdata", ram_wdata, 32'hD000_0000 + 32'(j));
      step;
    end
    @(negedge clk); chk("lit_sim_rd_acc", rd_rdy, 1);
    step; rd_req = 0;
    @(negedge clk);
    step;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("lit_sim_ret_valid", ret_valid, 1);
      chk("lit_sim_ret_data", ret_data, 32'hD000_0000 + 32'(j));
      chk("lit_sim_ret_last", ret_last, j == 3);
      step;
    end

    // Single half write with strobes 1100 at byte address 6.
    wr_req = 1; wr_type = 3'b001; wr_addr = 32'h6; wr_wstrb = 4'b1100;
    wr_data = '0; wr_data[31:0] = 32'hBEEF_0000;
    @(negedge clk); chk("lit_sw_acc", wr_rdy, 1);
    step; wr_req = 0;
    @(negedge clk);
    chk("lit_sw_en", ram_en, 1);
    chk("lit_sw_we", ram_we, 4'b1100);
    chk("lit_sw_addr", 32'(ram_addr), 1);
    chk("lit_sw_wdata", ram_wdata, 32'hBEEF_0000);
    step;
    @(negedge clk);
    chk("lit_sw_once_en", ram_en, 0);
    chk("lit_sw_wr_rdy", wr_rdy, 1);

    // Reset pulsed on the second beat of a line read.
    step; rd_req = 1; rd_type = 3'b100; rd_addr = 32'h40;
    @(negedge clk);
    step; rd_req = 0;
    @(negedge clk);
    step;
    @(negedge clk); chk("lit_mid_beat1", ret_valid, 1);
    step; rst = 1;
    @(negedge clk); chk("lit_mid_rst_valid", ret_valid, 0);
    step; rst = 0;
    @(negedge clk);
    chk("lit_mid_after_valid", ret_valid, 0);
    chk("lit_mid_after_last", ret_last, 0);
    chk("lit_mid_after_rdy", rd_rdy, 1);
    step;
    @(negedge clk);
    chk("lit_mid_later_valid", ret_valid, 0);
    chk("lit_mid_later_last", ret_last, 0);

    for (int k = 0; k < 2000; k++) begin
      step;
      rst      = ($urandom_range(0, 149) == 0);
      rd_req   = ($urandom_range(0, 2) == 0);
      wr_req   = ($urandom_range(0, 3) == 0);
      rd_type  = rand_type();
      wr_type  = rand_type();
      rd_addr  = rand_addr();
      wr_addr  = rand_addr();
      wr_wstrb = 4'($urandom_range(0, 15));
      for (int w = 0; w < int'(LW); w++) wr_data[32*w +: 32] = $urandom;
    end
    step;
    rst = 0; rd_req = 0; wr_req = 0;
    repeat (20) step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
